// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, FSM states, select codes.
// Pure definitions; no latency, no flow control.
package ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Bit 3 is the halted flag; HALT shares the visible code 001 with ID.
  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1001
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PCSRC_PC4  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_RS   = 2'b10;
  localparam logic [1:0] PCSRC_JUMP = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       ext_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic       reg_wre;
    logic       wr_reg_data;
    logic       db_data_src;
    logic       data_mem_rw;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_alu_inst(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT};
  endfunction

  function automatic logic is_imm_inst(input logic [5:0] op);
    return op inside {OP_ADDI, OP_ORI};
  endfunction

  // Returns {alu_op, alu_src_a, alu_src_b} for the register/immediate arithmetic group.
  function automatic logic [4:0] alu_fields(input logic [5:0] op);
    logic [4:0] f;
    case (op)
      OP_SUB:  f = {ALU_SUB, 1'b0, 1'b0};
      OP_ADDI: f = {ALU_ADD, 1'b0, 1'b1};
      OP_OR:   f = {ALU_OR,  1'b0, 1'b0};
      OP_AND:  f = {ALU_AND, 1'b0, 1'b0};
      OP_ORI:  f = {ALU_OR,  1'b0, 1'b1};
      OP_SLL:  f = {ALU_SLL, 1'b1, 1'b0};
      OP_SLT:  f = {ALU_SLT, 1'b0, 1'b0};
      default: f = {ALU_ADD, 1'b0, 1'b0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, opcode, zero) into datapath strobes and next state.
// Zero latency; no flow control.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  output ctrl_t      o_ctrl,
  output state_t     o_next
);

  always_comb begin
    o_ctrl         = '0;
    o_ctrl.ext_sel = (i_opcode != OP_ORI);
    o_next         = i_state;

    case (i_state)
      S_IF: begin
        o_ctrl.ins_mem_rw = 1'b1;
        o_ctrl.ir_wre     = 1'b1;
        o_next            = S_ID;
      end
      S_ID: begin
        if (is_alu_inst(i_opcode)) begin
          o_next = S_EXE_AL;
        end else begin
          case (i_opcode)
            OP_BEQ:       o_next = S_EXE_BR;
            OP_LW, OP_SW: o_next = S_EXE_LS;
            OP_HALT:      o_next = S_HALT;
            OP_J: begin
              o_ctrl.pc_src = PCSRC_JUMP;
              o_ctrl.pc_wre = 1'b1;
              o_next        = S_IF;
            end
            OP_JR: begin
              o_ctrl.pc_src = PCSRC_RS;
              o_ctrl.pc_wre = 1'b1;
              o_next        = S_IF;
            end
            OP_JAL: begin
              o_ctrl.pc_src      = PCSRC_JUMP;
              o_ctrl.reg_dst     = REGDST_RA;
              o_ctrl.wr_reg_data = 1'b0;
              o_ctrl.reg_wre     = 1'b1;
              o_ctrl.pc_wre      = 1'b1;
              o_next             = S_IF;
            end
            // Unknown opcodes retire as a NOP so the PC keeps moving.
            default: begin
              o_ctrl.pc_src = PCSRC_PC4;
              o_ctrl.pc_wre = 1'b1;
              o_next        = S_IF;
            end
          endcase
        end
      end
      S_EXE_AL: begin
        {o_ctrl.alu_op, o_ctrl.alu_src_a, o_ctrl.alu_src_b} = alu_fields(i_opcode);
        o_next = S_WB_AL;
      end
      S_WB_AL: begin
        // ALU controls stay asserted so the result is stable while it is written back.
        {o_ctrl.alu_op, o_ctrl.alu_src_a, o_ctrl.alu_src_b} = alu_fields(i_opcode);
        o_ctrl.reg_wre     = 1'b1;
        o_ctrl.wr_reg_data = 1'b1;
        o_ctrl.reg_dst     = is_imm_inst(i_opcode) ? REGDST_RT : REGDST_RD;
        o_ctrl.pc_src      = PCSRC_PC4;
        o_ctrl.pc_wre      = 1'b1;
        o_next             = S_IF;
      end
      S_EXE_BR: begin
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.pc_src = i_zero ? PCSRC_BR : PCSRC_PC4;
        o_ctrl.pc_wre = 1'b1;
        o_next        = S_IF;
      end
      S_EXE_LS: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.alu_src_b = 1'b1;
        o_next           = S_MEM;
      end
      S_MEM: begin
        if (i_opcode == OP_SW) begin
          o_ctrl.data_mem_rw = 1'b1;
          o_ctrl.pc_wre      = 1'b1;
          o_next             = S_IF;
        end else begin
          o_next = S_WB_LD;
        end
      end
      S_WB_LD: begin
        o_ctrl.reg_wre     = 1'b1;
        o_ctrl.db_data_src = 1'b1;
        o_ctrl.wr_reg_data = 1'b1;
        o_ctrl.reg_dst     = REGDST_RT;
        o_ctrl.pc_wre      = 1'b1;
        o_next             = S_IF;
      end
      S_HALT:  o_next = S_HALT;
      default: o_next = S_IF;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencing plus retired-instruction counter.
// Latency j/jr/jal 2, beq 3, ALU and sw 4, lw 5 cycles; never stalls, HALT holds until reset.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             PCWre,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             ExtSel,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       RegDst,
  output logic             RegWre,
  output logic             WrRegData,
  output logic             DBDataSrc,
  output logic             DataMemRW,
  output logic [1:0]       PCSrc,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  logic [CNT_W-1:0] r_instret;
  state_t           w_next;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;

  ctrl_decode u_decode (
    .i_state  (r_state),
    .i_opcode (opcode),
    .i_zero   (zero),
    .o_ctrl   (w_ctrl),
    .o_next   (w_next)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IF;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_ctrl.pc_wre)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Strobes are muted while reset is held so a mid-instruction reset commits nothing.
  assign w_out = Reset ? w_ctrl : '0;

  assign PCWre     = w_out.pc_wre;
  assign IRWre     = w_out.ir_wre;
  assign InsMemRW  = w_out.ins_mem_rw;
  assign ExtSel    = w_out.ext_sel;
  assign ALUSrcA   = w_out.alu_src_a;
  assign ALUSrcB   = w_out.alu_src_b;
  assign ALUOp     = w_out.alu_op;
  assign RegDst    = w_out.reg_dst;
  assign RegWre    = w_out.reg_wre;
  assign WrRegData = w_out.wr_reg_data;
  assign DBDataSrc = w_out.db_data_src;
  assign DataMemRW = w_out.data_mem_rw;
  assign PCSrc     = w_out.pc_src;
  assign state     = r_state[2:0];
  assign halted    = r_state[3];
  assign instret   = r_instret;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed + random instruction stream against a per-instruction cycle-table model.
module tb_multi_cycle_ctrl;

  localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_ADDI = 6'b000010;
  localparam logic [5:0] O_OR  = 6'b010000, O_AND = 6'b010001, O_ORI  = 6'b010010;
  localparam logic [5:0] O_SLL = 6'b011000, O_SLT = 6'b100110, O_SW   = 6'b110000;
  localparam logic [5:0] O_LW  = 6'b110001, O_BEQ = 6'b110100, O_J    = 6'b111000;
  localparam logic [5:0] O_JR  = 6'b111001, O_JAL = 6'b111010, O_HALT = 6'b111111;

  typedef struct packed {
    logic       pcwre;
    logic       irwre;
    logic       imrw;
    logic       ext;
    logic       srca;
    logic       srcb;
    logic [2:0] aluop;
    logic [1:0] regdst;
    logic       regwre;
    logic       wrsel;
    logic       dbsrc;
    logic       dmrw;
    logic [1:0] pcsrc;
    logic [2:0] st;
    logic       hlt;
  } vec_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
  logic [2:0]  ALUOp;
  logic [1:0]  RegDst;
  logic        RegWre, WrRegData, DBDataSrc, DataMemRW;
  logic [1:0]  PCSrc;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instret;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_instret = '0;
  vec_t        obs;

  multi_cycle_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .RegWre(RegWre), .WrRegData(WrRegData), .DBDataSrc(DBDataSrc),
    .DataMemRW(DataMemRW), .PCSrc(PCSrc), .state(state), .halted(halted),
    .instret(instret)
  );

  always #5 CLK = ~CLK;

  assign obs = {PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegDst,
                RegWre, WrRegData, DBDataSrc, DataMemRW, PCSrc, state, halted};

  function automatic logic arith(input logic [5:0] op);
    return op inside {O_ADD, O_SUB, O_ADDI, O_OR, O_AND, O_ORI, O_SLL, O_SLT};
  endfunction

  function automatic logic defined(input logic [5:0] op);
    return arith(op) || (op inside {O_SW, O_LW, O_BEQ, O_J, O_JR, O_JAL, O_HALT});
  endfunction

  // Cycles an instruction occupies before the next fetch (halt: IF+ID, then parks).
  function automatic int ilen(input logic [5:0] op);
    if (arith(op) || op == O_SW) return 4;
    if (op == O_LW) return 5;
    if (op == O_BEQ) return 3;
    return 2;
  endfunction

  // Expected outputs in cycle k (0 = fetch) of instruction op.
  function automatic vec_t exp_cycle(input logic [5:0] op, input int k, input logic z);
    vec_t e;
    e = '0;
    e.ext = (op != O_ORI);
    if (k == 0) begin
      e.imrw = 1'b1; e.irwre = 1'b1; e.st = 3'b000;
    end else if (k == 1) begin
      e.st = 3'b001;
      if (op == O_J) begin e.pcsrc = 2'b11; e.pcwre = 1'b1; end
      else if (op == O_JR) begin e.pcsrc = 2'b10; e.pcwre = 1'b1; end
      else if (op == O_JAL) begin
        e.pcsrc = 2'b11; e.regdst = 2'b00; e.wrsel = 1'b0; e.regwre = 1'b1; e.pcwre = 1'b1;
      end else if (!defined(op)) e.pcwre = 1'b1;
    end else if (arith(op)) begin
      case (op)
        O_SUB:  e.aluop = 3'd1;
        O_OR:   e.aluop = 3'd3;
        O_AND:  e.aluop = 3'd4;
        O_ORI:  e.aluop = 3'd3;
        O_SLL:  e.aluop = 3'd2;
        O_SLT:  e.aluop = 3'd5;
        default: e.aluop = 3'd0;
      endcase
      e.srca = (op == O_SLL);
      e.srcb = (op == O_ADDI) || (op == O_ORI);
      if (k == 2) e.st = 3'b110;
      else begin
        e.st = 3'b111; e.regwre = 1'b1; e.wrsel = 1'b1; e.pcwre = 1'b1;
        e.regdst = e.srcb ? 2'b01 : 2'b10;
      end
    end else if (op == O_BEQ) begin
      e.st = 3'b101; e.aluop = 3'd1; e.pcsrc = z ? 2'b01 : 2'b00; e.pcwre = 1'b1;
    end else if (k == 2) begin
      e.st = 3'b010; e.aluop = 3'd0; e.srcb = 1'b1;
    end else if (k == 3) begin
      e.st = 3'b011;
      if (op == O_SW) begin e.dmrw = 1'b1; e.pcwre = 1'b1; end
    end else begin
      e.st = 3'b100; e.regwre = 1'b1; e.dbsrc = 1'b1; e.wrsel = 1'b1;
      e.regdst = 2'b01; e.pcwre = 1'b1;
    end
    return e;
  endfunction

  task automatic check_vec(input string tag, input vec_t e);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: outputs observed %h expected %h (t=%0t)", tag, obs, e, $time);
    end
  endtask

  task automatic check_cnt(input string tag);
    n_cmp++;
    assert (instret === m_instret) else begin
      n_bad++;
      $error("FAIL %s: instret observed %0d expected %0d (t=%0t)", tag, instret, m_instret, $time);
    end
  endtask

  // Runs one instruction from its fetch cycle; zf<0 randomises zero each cycle.
  // abort_k>=0 asserts reset after checking that cycle and abandons the instruction.
  task automatic run_instr(input logic [5:0] op, input int zf, input int abort_k);
    for (int k = 0; k < ilen(op); k++) begin
      opcode = op;
      zero   = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
      @(negedge CLK);
      check_vec($sformatf("op%b_c%0d", op, k), exp_cycle(op, k, zero));
      check_cnt($sformatf("cnt_op%b_c%0d", op, k));
      if (k == abort_k) begin
        Reset = 1'b0;
        m_instret = '0;
        #1;
        check_vec("reset_mid_instr", '0);
        check_cnt("reset_mid_instr_cnt");
        @(posedge CLK); #1;
        check_vec("reset_held", '0);
        Reset = 1'b1;
        return;
      end
      @(posedge CLK); #1;
    end
    if (op != O_HALT) m_instret = m_instret + 32'd1;
  endtask

  initial begin
    logic [5:0] pool [13];
    logic [5:0] op;
    vec_t       eh;
    pool = '{O_ADD, O_SUB, O_ADDI, O_OR, O_AND, O_ORI, O_SLL, O_SLT,
             O_SW, O_LW, O_BEQ, O_J, O_JR};

    Reset = 1'b0; opcode = O_ADD; zero = 1'b0;
    repeat (2) @(negedge CLK);
    check_vec("reset_state", '0);
    check_cnt("reset_cnt");
    @(posedge CLK); #1;
    Reset = 1'b1;

    run_instr(O_ADDI, -1, -1);
    run_instr(O_ORI,  -1, -1);
    run_instr(O_BEQ,   1, -1);
    run_instr(O_BEQ,   0, -1);
    run_instr(O_LW,   -1, -1);
    run_instr(O_SW,   -1, -1);
    run_instr(O_SLL,  -1, -1);
    run_instr(O_LW,   -1, 2);
    run_instr(O_ADD,  -1, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (defined(op));
      end else begin
        op = pool[$urandom_range(0, 12)];
      end
      run_instr(op, -1, -1);
    end

    run_instr(O_JAL, -1, -1);
    run_instr(O_HALT, -1, -1);
    eh = '0; eh.st = 3'b001; eh.hlt = 1'b1; eh.ext = 1'b1;
    for (int c = 0; c < 20; c++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check_vec($sformatf("halt_c%0d", c), eh);
      check_cnt($sformatf("halt_cnt_c%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
